// File: rtl/oqpsk_rx_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oqpsk_rx_packer_pkg
//  Description : Shared typedefs for the OQPSK transmit and receive packers.
//  Revision    : 1.0 - initial release
// ============================================================================
package oqpsk_rx_packer_pkg;

    // Receive-side packer state
    typedef enum logic [1:0] {
        RX_IDLE      = 2'd0,
        RX_RECEIVE   = 2'd1,
        RX_FLUSH     = 2'd2,
        RX_HOLD_LAST = 2'd3
    } reception_state_t;

    // Transmit-side packer state
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LOAD  = 2'd1,
        TX_SHIFT = 2'd2,
        TX_DONE  = 2'd3
    } transmission_state_t;

endpackage
`default_nettype wire

// File: rtl/oqpsk_rx_packer_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_component_slicer
//  Description : Sign slicer for one OQPSK component (I or Q). Takes a hard
//                decision at DECISION_PHASE and writes it into a per-word
//                bit register at the current symbol-pair index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_component_slicer #(
    parameter int DECISION_PHASE = 1,
    parameter int PHASE_WIDTH    = 2,
    parameter int HALF_WIDTH     = 8,
    parameter int INDEX_WIDTH    = 3
) (
    input  logic                   aclk,
    input  logic                   sresetn,
    input  logic                   i_consume,
    input  logic [PHASE_WIDTH-1:0] i_phase,
    input  logic                   i_sample_msb,
    input  logic [INDEX_WIDTH-1:0] i_bit_index,
    input  logic                   i_clear,
    output logic [HALF_WIDTH-1:0]  o_bits,
    output logic [HALF_WIDTH-1:0]  o_bits_next
);

    logic [HALF_WIDTH-1:0] bits_q;
    logic [HALF_WIDTH-1:0] bits_d;
    logic                  w_decide;

    assign w_decide = i_consume && (i_phase == PHASE_WIDTH'(DECISION_PHASE));

    // Insert the current decision (non-negative sample -> 1); clear wins for the stored copy
    always_comb begin
        o_bits_next = bits_q;
        if (w_decide) begin
            o_bits_next[i_bit_index] = ~i_sample_msb;
        end
        bits_d = i_clear ? '0 : o_bits_next;
    end

    // Decision bit register
    always_ff @(posedge aclk or negedge sresetn) begin
        if (!sresetn) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign o_bits = bits_q;

endmodule
`default_nettype wire

// File: rtl/oqpsk_rx_packer.sv
`default_nettype none
// ============================================================================
//  Module      : oqpsk_rx_packer
//  Description : OQPSK receive packer. Slices oversampled I/Q samples into
//                bit pairs (I offset half a symbol from Q) and packs them into
//                AXI-Stream words, flushing partial words at end of frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module oqpsk_rx_packer
    import oqpsk_rx_packer_pkg::*;
#(
    parameter int SAMPLES_PER_SYMBOL     = 4,
    parameter int SAMPLE_WIDTH           = 16,
    parameter int C_M00_AXIS_TDATA_WIDTH = 16
) (
    input  logic                                       aclk,
    input  logic                                       sresetn,
    input  logic [2*SAMPLE_WIDTH-1:0]                  s_axis_tdata,
    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    input  logic                                       s_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]          m_axis_tdata,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic                                       m_axis_tlast,
    output logic [$clog2(C_M00_AXIS_TDATA_WIDTH/2)-1:0] bit_counter_out,
    output reception_state_t                           reception_state_out,
    output logic                                       end_of_reception,
    output logic                                       frame_error
);

    localparam int HALF_WIDTH  = C_M00_AXIS_TDATA_WIDTH / 2;
    localparam int INDEX_WIDTH = $clog2(HALF_WIDTH);
    localparam int PHASE_WIDTH = $clog2(SAMPLES_PER_SYMBOL);
    localparam int I_PHASE     = SAMPLES_PER_SYMBOL / 2 - 1;
    localparam int Q_PHASE     = SAMPLES_PER_SYMBOL - 1;

    reception_state_t                   state_q, state_d;
    logic [PHASE_WIDTH-1:0]             phase_q, phase_d;
    logic [INDEX_WIDTH-1:0]             bit_cnt_q, bit_cnt_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic                               m_tvalid_q, m_tvalid_d;
    logic                               m_tlast_q, m_tlast_d;
    logic                               frame_error_q, frame_error_d;

    logic                               w_collecting;
    logic                               w_consume;
    logic                               w_tlast_in;
    logic                               w_q_decide;
    logic                               w_word_done;
    logic                               w_out_accept;
    logic                               w_to_idle;
    logic                               w_slicer_clear;
    logic [HALF_WIDTH-1:0]              w_i_bits, w_i_next, w_q_bits, w_q_next;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]  w_word_next, w_word_held;
    logic                               w_unused_sample_bits;

    // Only the sign bits feed the slicers
    assign w_unused_sample_bits = &{1'b0, s_axis_tdata[SAMPLE_WIDTH-2:0],
                                   s_axis_tdata[2*SAMPLE_WIDTH-2:SAMPLE_WIDTH]};

    assign w_collecting   = (state_q == RX_IDLE) || (state_q == RX_RECEIVE);
    assign w_consume      = s_axis_tvalid && s_axis_tready;
    assign w_tlast_in     = w_consume && s_axis_tlast;
    assign w_q_decide     = w_consume && (phase_q == PHASE_WIDTH'(Q_PHASE));
    assign w_word_done    = w_q_decide && (bit_cnt_q == INDEX_WIDTH'(HALF_WIDTH - 1));
    assign w_out_accept   = m_tvalid_q && m_axis_tready;
    assign w_to_idle      = (state_q == RX_HOLD_LAST) && w_out_accept;
    assign w_slicer_clear = w_word_done || w_to_idle;

    rx_component_slicer #(
        .DECISION_PHASE (I_PHASE),
        .PHASE_WIDTH    (PHASE_WIDTH),
        .HALF_WIDTH     (HALF_WIDTH),
        .INDEX_WIDTH    (INDEX_WIDTH)
    ) u_slicer_i (
        .aclk         (aclk),
        .sresetn      (sresetn),
        .i_consume    (w_consume),
        .i_phase      (phase_q),
        .i_sample_msb (s_axis_tdata[SAMPLE_WIDTH-1]),
        .i_bit_index  (bit_cnt_q),
        .i_clear      (w_slicer_clear),
        .o_bits       (w_i_bits),
        .o_bits_next  (w_i_next)
    );

    rx_component_slicer #(
        .DECISION_PHASE (Q_PHASE),
        .PHASE_WIDTH    (PHASE_WIDTH),
        .HALF_WIDTH     (HALF_WIDTH),
        .INDEX_WIDTH    (INDEX_WIDTH)
    ) u_slicer_q (
        .aclk         (aclk),
        .sresetn      (sresetn),
        .i_consume    (w_consume),
        .i_phase      (phase_q),
        .i_sample_msb (s_axis_tdata[2*SAMPLE_WIDTH-1]),
        .i_bit_index  (bit_cnt_q),
        .i_clear      (w_slicer_clear),
        .o_bits       (w_q_bits),
        .o_bits_next  (w_q_next)
    );

    // Pair k: I at bit 2k, Q at bit 2k+1
    generate
        for (genvar k = 0; k < HALF_WIDTH; k++) begin : g_interleave
            assign w_word_next[2*k]   = w_i_next[k];
            assign w_word_next[2*k+1] = w_q_next[k];
            assign w_word_held[2*k]   = w_i_bits[k];
            assign w_word_held[2*k+1] = w_q_bits[k];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge aclk or negedge sresetn) begin
        if (!sresetn) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE, RX_RECEIVE: begin
                if (w_tlast_in) begin
                    state_d = w_word_done ? RX_HOLD_LAST : RX_FLUSH;
                end else if (w_consume) begin
                    state_d = RX_RECEIVE;
                end
            end
            RX_FLUSH:     state_d = RX_HOLD_LAST;
            RX_HOLD_LAST: if (w_out_accept) state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    // FSM outputs: input stalls on output backpressure and across the frame tail
    always_comb begin
        s_axis_tready    = !(m_tvalid_q && !m_axis_tready) && w_collecting;
        end_of_reception = w_to_idle;
    end

    // Datapath next values: counters, output word register, error pulse
    always_comb begin
        phase_d       = phase_q;
        bit_cnt_d     = bit_cnt_q;
        m_tdata_d     = m_tdata_q;
        m_tvalid_d    = m_tvalid_q;
        m_tlast_d     = m_tlast_q;
        frame_error_d = w_tlast_in && (phase_q != PHASE_WIDTH'(Q_PHASE));

        if (w_to_idle) begin
            phase_d   = '0;
            bit_cnt_d = '0;
        end else if (w_consume) begin
            phase_d = (phase_q == PHASE_WIDTH'(Q_PHASE)) ? '0 : phase_q + PHASE_WIDTH'(1);
            if (w_q_decide) begin
                bit_cnt_d = w_word_done ? '0 : bit_cnt_q + INDEX_WIDTH'(1);
            end
        end

        if (w_out_accept) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end
        // A new word overrides the accept above so back-to-back words have no bubble
        if (w_word_done) begin
            m_tdata_d  = w_word_next;
            m_tvalid_d = 1'b1;
            m_tlast_d  = s_axis_tlast;
        end else if (state_q == RX_FLUSH) begin
            m_tdata_d  = w_word_held;
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge aclk or negedge sresetn) begin
        if (!sresetn) begin
            phase_q       <= '0;
            bit_cnt_q     <= '0;
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            bit_cnt_q     <= bit_cnt_d;
            m_tdata_q     <= m_tdata_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tlast_q     <= m_tlast_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign m_axis_tdata        = m_tdata_q;
    assign m_axis_tvalid       = m_tvalid_q;
    assign m_axis_tlast        = m_tlast_q;
    assign bit_counter_out     = bit_cnt_q;
    assign reception_state_out = state_q;
    assign frame_error         = frame_error_q;

endmodule
`default_nettype wire
